// File: rtl/cache_controller.sv
// Cache controller FSM: sequences hit, write-back and refill strobes for the cache datapath
// and keeps saturating hit/miss/write-back statistics.
module cache_controller #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_type,
  output logic                 cpu_stall,
  output logic                 cpu_done,
  input  logic                 cache_hit,
  input  logic                 cache_dirty,
  input  logic                 mem_ack,
  output logic                 read_en_cache,
  output logic                 write_en_cache,
  output logic                 read_en_mem,
  output logic                 write_en_mem,
  output logic                 req_type,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] wb_cnt,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCompare   = 3'd1,
    StWriteBack = 3'd2,
    StAllocate  = 3'd3,
    StDone      = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic   req_type_q, req_type_d;
  logic   first_pass_q, first_pass_d;
  logic   hit_inc, miss_inc, wb_inc;
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_type_q   <= 1'b0;
      first_pass_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_type_q   <= req_type_d;
      first_pass_q <= first_pass_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_type_d     = req_type_q;
    first_pass_d   = first_pass_q;
    cpu_stall      = 1'b1;
    cpu_done       = 1'b0;
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    read_en_mem    = 1'b0;
    write_en_mem   = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    wb_inc         = 1'b0;
    case (state_q)
      StIdle: begin
        cpu_stall = 1'b0;
        if (cpu_req_valid) begin
          req_type_d   = cpu_req_type;
          first_pass_d = 1'b1;
          state_d      = StCompare;
        end
      end
      StCompare: begin
        if (cache_hit) begin
          read_en_cache  = ~req_type_q;
          write_en_cache = req_type_q;
          hit_inc        = first_pass_q;
          state_d        = StDone;
        end else begin
          // Only the first lookup of a request counts; re-lookups after refill do not.
          miss_inc = first_pass_q;
          state_d  = cache_dirty ? StWriteBack : StAllocate;
        end
      end
      StWriteBack: begin
        read_en_cache = 1'b1;
        write_en_mem  = 1'b1;
        if (mem_ack) begin
          wb_inc  = 1'b1;
          state_d = StAllocate;
        end
      end
      StAllocate: begin
        read_en_mem = 1'b1;
        if (mem_ack) begin
          write_en_cache = 1'b1;
          first_pass_d   = 1'b0;
          state_d        = StCompare;
        end
      end
      StDone: begin
        cpu_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (hit_inc && hit_cnt_q != CntMax) hit_cnt_q <= hit_cnt_q + CntOne;
      if (miss_inc && miss_cnt_q != CntMax) miss_cnt_q <= miss_cnt_q + CntOne;
      if (wb_inc && wb_cnt_q != CntMax) wb_cnt_q <= wb_cnt_q + CntOne;
    end
  end

  assign req_type = req_type_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
  assign state    = state_q;

endmodule
